falcon_modadd_arb: RTL and testbench
====================================

Name: falcon_modadd_arb

Overview:
- Shares a single Falcon modular adder (q = 12289) between NREQ requesters.
- Round-robin arbitration with a valid/ready handshake on every requester port.
- Two-stage registered pipeline: operand register, then result register.
- Tags each result with the index of the requester that issued it, so consumers (NTT butterflies, polynomial add loops) can demultiplex.
- Instantiates the existing falcon_modadd combinationally between the two stages.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of the requester index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; handshake when valid & ready.
- req_a  input  14*NREQ  packed operand A; requester i uses bits [14*i+13:14*i]; value < 12289.
- req_b  input  14*NREQ  packed operand B, same packing and range as req_a.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_c  output  14  (A+B) mod 12289.
- out_id  output  IDW  index of the requester that issued this result.

Behaviour:
- Reset (asynchronous, rst=1):
  - s1_valid=0, s2_valid=0; all data and id registers cleared to 0.
  - out_valid=0, out_c=0, out_id=0, req_ready=0.
  - Round-robin pointer set to NREQ-1, so requester 0 has top priority on the first arbitration.
  - In-flight operations are discarded; no result is emitted for them.
- Pipeline advance, combinational:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
- Arbitration, combinational:
  - Search req_valid starting at pointer+1 and wrapping modulo NREQ.
  - The first asserted requester is granted.
  - req_ready[i] = adv1 & grant[i]; at most one bit set; req_ready is 0 when no requester is valid.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
- On acceptance:
  - s1 loads A, B and the grant index; s1_valid=1.
  - Pointer updates to the granted index.
  - The pointer is unchanged in cycles with no acceptance.
- Stage 1 with adv1=1 and no request: s1_valid goes to 0.
- Stage 2 with adv2=1: s2 loads falcon_modadd(s1_a, s1_b), s1_id and s1_valid.
- Outputs: out_valid=s2_valid, out_c=s2_c, out_id=s2_id.
  - While out_valid=1 and out_ready=0, out_c and out_id hold stable.
- Latency: a handshake at edge N gives out_valid at edge N+2 when there is no backpressure.
- Throughput: one operation per cycle sustained.
- Full condition: both stages valid and out_ready=0 → all req_ready=0.
- Simultaneous drain and fill:
  - With s2 full and out_ready=1 in the same cycle as a new acceptance, all three events occur.
  - No bubble is inserted and nothing is lost.
- Arithmetic:
  - 15-bit sum; subtract 12289 when sum ≥ 12289.
  - Output always < 12289 for in-range inputs.
  - Out-of-range inputs are not checked; the result is whatever falcon_modadd produces.
- Fairness: with all requesters continuously valid, grants rotate strictly 0,1,...,NREQ-1,0,...
- A requester holding valid waits at most NREQ-1 accepted operations before it is granted.

Test Plan:
- Basic latency: single requester 0, A=100, B=200 → out_c=300, out_id=0, out_valid exactly 2 cycles after the handshake.
- Wrap boundary:
  - A=12288, B=1 → out_c=0.
  - A=6000, B=7000 → out_c=711.
  - A=12288, B=12288 → out_c=12287.
  - A=0, B=0 → out_c=0.
- Contention: all 4 requesters continuously valid, out_ready=1 → out_id sequence 0,1,2,3,0,1 over six consecutive cycles; one result per cycle.
- Backpressure:
  - Stream from requester 2 and hold out_ready=0 for 5 cycles.
  - Exactly 2 operations are accepted; req_ready then stays 0.
  - out_c/out_id hold stable.
  - On out_ready=1, results drain in order with no loss and no duplication.
- Skip and pointer: only requesters 1 and 3 valid, starting from reset → grants 1,3,1,3. Requester 0 becoming valid after a grant to 3 gets the next grant.
- Reset mid-operation:
  - Assert rst asynchronously with both stages full.
  - out_valid drops immediately, with no clock edge required.
  - After release, the first request from requester 0 is granted ahead of requester 1.

Source files
------------

// File: rtl/falcon_modadd_arb.sv
// falcon_modadd_arb: round-robin shared Falcon (q=12289) modular adder, two-stage pipeline, id-tagged results
module falcon_modadd (
  input  logic [13:0] a,
  input  logic [13:0] b,
  output logic [13:0] c
);
  logic [14:0] s;
  assign s = {1'b0, a} + {1'b0, b};
  assign c = s >= 15'd12289 ? 14'(s - 15'd12289) : s[13:0];
endmodule

module falcon_modadd_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [14*NREQ-1:0]   req_a,
  input  logic [14*NREQ-1:0]   req_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [13:0]          out_c,
  output logic [IDW-1:0]       out_id
);
  logic [IDW-1:0] ptr, gid, s1_id, s2_id;
  logic           any, acc, adv1, adv2, s1_valid, s2_valid;
  logic [13:0]    s1_a, s1_b, s2_c, sum_c;
  assign adv2 = !s2_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  // scan from farthest to nearest so the requester closest after ptr wins
  always_comb begin
    any = 1'b0;
    gid = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IDW'((int'(ptr) + k) % NREQ)]) begin
        any = 1'b1;
        gid = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign acc       = adv1 && any && !rst;
  assign req_ready = acc ? NREQ'(1) << gid : '0;
  falcon_modadd u_add (.a(s1_a), .b(s1_b), .c(sum_c));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= IDW'(NREQ - 1);
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_id    <= '0;
    end else begin
      if (adv1) s1_valid <= acc;
      if (acc) begin
        s1_a  <= req_a[14*gid +: 14];
        s1_b  <= req_b[14*gid +: 14];
        s1_id <= gid;
        ptr   <= gid;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_c     <= sum_c;
        s2_id    <= s1_id;
      end
    end
  end
  assign out_valid = s2_valid;
  assign out_c     = s2_c;
  assign out_id    = s2_id;
endmodule

// File: tb/tb_falcon_modadd_arb.sv
// tb_falcon_modadd_arb: random and directed stimulus against a queue-based reference of the shared adder
module tb_falcon_modadd_arb;
  localparam int NREQ = 4, IDW = 2, Q = 12289;
  typedef struct {int c; int id; int t;} item_t;
  logic clk = 0, rst = 1, out_ready = 0, out_valid;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [14*NREQ-1:0] req_a = '0, req_b = '0;
  logic [13:0] out_c;
  logic [IDW-1:0] out_id;
  item_t q[$];
  int ptr = NREQ - 1, cyc = 0, n_vec = 0, n_err = 0, exp_v;
  always #5 clk = ~clk;
  falcon_modadd_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_id(out_id)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [14*NREQ-1:0] put(input int i, input int v);
    logic [14*NREQ-1:0] r = '0;
    r[14*i +: 14] = 14'(v);
    return r;
  endfunction
  function automatic logic [14*NREQ-1:0] rnd();
    logic [14*NREQ-1:0] r = '0;
    for (int i = 0; i < NREQ; i++) r[14*i +: 14] = 14'($urandom_range(0, Q - 1));
    return r;
  endfunction
  // one cycle: drive, check the grant against the round-robin rule, record accepted work
  task automatic cycle(input logic [NREQ-1:0] v, input logic [14*NREQ-1:0] a,
                       input logic [14*NREQ-1:0] b, input logic ordy);
    int g;
    @(negedge clk);
    cyc++;
    req_valid = v; req_a = a; req_b = b; out_ready = ordy;
    #1;
    g = -1;
    for (int k = 1; k <= NREQ; k++) if (g < 0 && v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
    if (q.size() == 2 && !ordy) g = -1;
    chk("req_ready", int'(req_ready), g < 0 ? 0 : (1 << g));
    if (g >= 0) begin
      q.push_back('{(int'(a[14*g +: 14]) + int'(b[14*g +: 14])) % Q, g, cyc});
      ptr = g;
    end
  endtask
  always @(negedge clk) if (!rst) begin
    #2;
    exp_v = (q.size() > 0 && cyc >= q[0].t + 2) ? 1 : 0;
    chk("out_valid", int'(out_valid), exp_v);
    if (out_valid && q.size() > 0) begin
      chk("out_c", int'(out_c), q[0].c);
      chk("out_id", int'(out_id), q[0].id);
      if (out_ready) void'(q.pop_front());
    end
  end
  initial begin
    int wa[4] = '{12288, 6000, 12288, 0};
    int wb[4] = '{1, 7000, 12288, 0};
    repeat (2) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst req_ready", int'(req_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_c", int'(out_c), 0);
    chk("rst out_id", int'(out_id), 0);
    req_valid = '0;
    @(posedge clk); #2 rst = 0;
    cycle(4'b0001, put(0, 100), put(0, 200), 1);
    repeat (3) cycle('0, '0, '0, 1);
    for (int i = 0; i < 4; i++) cycle(4'b0001, put(0, wa[i]), put(0, wb[i]), 1);
    repeat (3) cycle('0, '0, '0, 1);
    repeat (8) cycle('1, rnd(), rnd(), 1);
    repeat (3) cycle('0, '0, '0, 1);
    repeat (5) cycle(4'b0100, rnd(), rnd(), 0);
    repeat (4) cycle('0, '0, '0, 1);
    repeat (4) cycle(4'b1010, rnd(), rnd(), 1);
    cycle(4'b1011, rnd(), rnd(), 1);
    repeat (3) cycle('0, '0, '0, 1);
    repeat (300) cycle(NREQ'($urandom), rnd(), rnd(), $urandom_range(0, 9) < 7);
    repeat (3) cycle('1, rnd(), rnd(), 0);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("async rst out_valid", int'(out_valid), 0);
    chk("async rst req_ready", int'(req_ready), 0);
    q.delete();
    ptr = NREQ - 1;
    @(posedge clk); #2 rst = 0;
    cycle(4'b0011, rnd(), rnd(), 1);
    repeat (4) cycle('0, '0, '0, 1);
    chk("drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
